adc_capture: RTL and testbench

ADC_CAPTURE -- requirements
Module: adc_capture

---
 rtl/adc_capture_pkg.sv | 22 ++
 rtl/adc_capture_fifo.sv | 59 +++++
 rtl/adc_capture.sv | 185 ++++++++++++++++++
 tb/tb_adc_capture.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/adc_capture_pkg.sv
// Shared types for the ADC serial capture block: recorder states, their 3-bit
// status encoding and the channel codes carried alongside each sample.
package adc_capture_pkg;

    localparam int REC_STATE_W = 3;

    typedef enum logic [REC_STATE_W-1:0] {
        S_IDLE  = 3'd0,
        S_SYNC  = 3'd1,
        S_DELAY = 3'd2,
        S_SHIFT = 3'd3,
        S_HOLD  = 3'd4
    } rec_state_t;

    localparam logic CH_LEFT  = 1'b0;
    localparam logic CH_RIGHT = 1'b1;

    function automatic logic [REC_STATE_W-1:0] rec_state_code(input rec_state_t s);
        return s;
    endfunction

endpackage

// File: rtl/adc_capture_fifo.sv
// Generic synchronous FIFO; head word visible combinationally, push/pop take effect next edge.
// A push on full is accepted only when a pop happens in the same cycle; otherwise it is dropped.
module adc_capture_fifo #(
    parameter int WIDTH = 17,
    parameter int DEPTH = 4
) (
    input  logic                     i_clk,
    input  logic                     i_rst,
    input  logic                     i_push,
    input  logic [WIDTH-1:0]         i_din,
    input  logic                     i_pop,
    output logic [WIDTH-1:0]         o_dout,
    output logic                     o_empty,
    output logic                     o_full,
    output logic [$clog2(DEPTH):0]   o_count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_rd_ptr;
    logic [AW-1:0]    r_wr_ptr;
    logic [CW-1:0]    r_count;
    logic             w_push;
    logic             w_pop;

    assign o_empty = (r_count == '0);
    assign o_full  = (r_count == CW'(DEPTH));
    assign w_pop   = i_pop & ~o_empty;
    assign w_push  = i_push & (~o_full | w_pop);

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else begin
            if (w_push) begin
                r_mem[r_wr_ptr] <= i_din;
                r_wr_ptr        <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    assign o_dout  = r_mem[r_rd_ptr];
    assign o_count = r_count;

endmodule

// File: rtl/adc_capture.sv
// Serial ADC capture (left-justified; I2S one-bit delay when ADC_CAPTURE_I2S_DELAY_EN is defined).
// Word enters the FIFO on the edge that samples its last bit; full FIFO drops new words (sticky overrun).
module adc_capture
    import adc_capture_pkg::*;
#(
    parameter int DATA_W   = 16,
    parameter int CHANNELS = 2,
    parameter int DEPTH    = 4
) (
    input  logic                     i_BCLK,
    input  logic                     i_rst,
    input  logic                     i_record,
    input  logic                     i_ADCLRCK,
    input  logic                     i_ADCDAT,
    input  logic                     i_ready,
    input  logic                     i_clr_err,
    output logic [DATA_W-1:0]        o_data,
    output logic                     o_channel,
    output logic                     o_valid,
    output logic [$clog2(DEPTH):0]   o_count,
    output logic                     o_overrun,
    output logic                     o_short,
    output logic [REC_STATE_W-1:0]   o_REC_STATE
);
    localparam int CNT_W     = $clog2(DATA_W + 1);
    localparam bit HAS_RIGHT = (CHANNELS > 1);
`ifdef ADC_CAPTURE_I2S_DELAY_EN
    localparam bit I2S_DLY = 1'b1;
`else
    localparam bit I2S_DLY = 1'b0;
`endif

    rec_state_t        r_state;
    rec_state_t        w_state_nxt;
    logic              r_lrck_d;
    // Only DATA_W-1 bits are kept: the final bit is taken straight from the pin at push time.
    logic [DATA_W-2:0] r_shift;
    logic [DATA_W-2:0] w_shift_nxt;
    logic [CNT_W-1:0]  r_bitcnt;
    logic [CNT_W-1:0]  w_bitcnt_nxt;
    logic              r_chan;
    logic              w_chan_nxt;
    logic              r_overrun;
    logic              r_short;

    logic              w_edge;
    logic              w_fall;
    logic              w_rise;
    logic              w_start_edge;
    logic              w_start;
    logic              w_push;
    logic              w_short_set;
    logic              w_pop;
    logic              w_full;
    logic              w_empty;
    logic [DATA_W-1:0] w_word;
    logic [DATA_W:0]   w_fifo_dout;

    assign w_edge       = (i_ADCLRCK != r_lrck_d);
    assign w_fall       = w_edge & ~i_ADCLRCK;
    assign w_rise       = w_edge & i_ADCLRCK;
    assign w_start_edge = w_fall | (w_rise & HAS_RIGHT);
    assign w_word       = {r_shift, i_ADCDAT};

    always_comb begin
        w_state_nxt  = r_state;
        w_shift_nxt  = r_shift;
        w_bitcnt_nxt = r_bitcnt;
        w_chan_nxt   = r_chan;
        w_start      = 1'b0;
        w_push       = 1'b0;
        w_short_set  = 1'b0;

        case (r_state)
            S_IDLE: begin
                if (i_record) w_state_nxt = S_SYNC;
            end
            S_SYNC: begin
                if (w_fall) w_start = 1'b1;
            end
            S_DELAY: begin
                if (w_start_edge) begin
                    w_short_set = 1'b1;
                    w_start     = 1'b1;
                end else begin
                    w_shift_nxt  = {{(DATA_W-2){1'b0}}, i_ADCDAT};
                    w_bitcnt_nxt = CNT_W'(1);
                    w_state_nxt  = S_SHIFT;
                end
            end
            S_SHIFT: begin
                if (w_start_edge) begin
                    w_short_set = 1'b1;
                    w_start     = 1'b1;
                end else begin
                    w_shift_nxt  = w_word[DATA_W-2:0];
                    w_bitcnt_nxt = r_bitcnt + 1'b1;
                    if (r_bitcnt == CNT_W'(DATA_W - 1)) begin
                        w_push      = 1'b1;
                        w_state_nxt = S_HOLD;
                    end
                end
            end
            S_HOLD: begin
                if (w_start_edge) w_start = 1'b1;
            end
            default: w_state_nxt = S_IDLE;
        endcase

        // A new word always restarts collection, including on a premature edge.
        if (w_start) begin
            w_chan_nxt = i_ADCLRCK ? CH_RIGHT : CH_LEFT;
            if (I2S_DLY) begin
                w_shift_nxt  = '0;
                w_bitcnt_nxt = '0;
                w_state_nxt  = S_DELAY;
            end else begin
                w_shift_nxt  = {{(DATA_W-2){1'b0}}, i_ADCDAT};
                w_bitcnt_nxt = CNT_W'(1);
                w_state_nxt  = S_SHIFT;
            end
        end

        if (!i_record) begin
            w_state_nxt  = S_IDLE;
            w_shift_nxt  = '0;
            w_bitcnt_nxt = '0;
            w_push       = 1'b0;
            w_short_set  = 1'b0;
        end
    end

    always_ff @(posedge i_BCLK) begin
        if (i_rst) begin
            r_state   <= S_IDLE;
            r_lrck_d  <= 1'b0;
            r_shift   <= '0;
            r_bitcnt  <= '0;
            r_chan    <= CH_LEFT;
            r_overrun <= 1'b0;
            r_short   <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_lrck_d  <= i_ADCLRCK;
            r_shift   <= w_shift_nxt;
            r_bitcnt  <= w_bitcnt_nxt;
            r_chan    <= w_chan_nxt;
            if (w_push && w_full && !w_pop) begin
                r_overrun <= 1'b1;
            end else if (i_clr_err) begin
                r_overrun <= 1'b0;
            end
            if (w_short_set) begin
                r_short <= 1'b1;
            end else if (i_clr_err) begin
                r_short <= 1'b0;
            end
        end
    end

    assign w_pop = ~w_empty & i_ready;

    adc_capture_fifo #(
        .WIDTH (DATA_W + 1),
        .DEPTH (DEPTH)
    ) u_fifo (
        .i_clk   (i_BCLK),
        .i_rst   (i_rst),
        .i_push  (w_push),
        .i_din   ({r_chan, w_word}),
        .i_pop   (w_pop),
        .o_dout  (w_fifo_dout),
        .o_empty (w_empty),
        .o_full  (w_full),
        .o_count (o_count)
    );

    assign o_data      = w_fifo_dout[DATA_W-1:0];
    assign o_channel   = w_fifo_dout[DATA_W];
    assign o_valid     = ~w_empty;
    assign o_overrun   = r_overrun;
    assign o_short     = r_short;
    assign o_REC_STATE = rec_state_code(r_state);

endmodule

// File: tb/tb_adc_capture.sv
// Directed serial frames against a stereo 16-bit capture and a mono companion;
// expected {channel,data} words queue up and monitors compare every accepted head word.
module tb_adc_capture;
    import adc_capture_pkg::*;

`ifdef ADC_CAPTURE_I2S_DELAY_EN
    localparam int DLY = 1;
`else
    localparam int DLY = 0;
`endif

    logic        clk = 1'b0;
    logic        rst, record, record1, lrck, dat, ready, clr;
    logic        ready1 = 1'b1;
    logic [15:0] d0, d1;
    logic        ch0, ch1, v0, v1, ovr0, ovr1, sh0, sh1;
    logic [2:0]  cnt0, cnt1, st0, st1;

    int n_vec = 0;
    int n_bad = 0;
    logic [16:0] q0[$];
    logic [16:0] q1[$];

    always #5 clk = ~clk;

    adc_capture #(.DATA_W(16), .CHANNELS(2), .DEPTH(4)) u_dut (
        .i_BCLK(clk), .i_rst(rst), .i_record(record), .i_ADCLRCK(lrck), .i_ADCDAT(dat),
        .i_ready(ready), .i_clr_err(clr), .o_data(d0), .o_channel(ch0), .o_valid(v0),
        .o_count(cnt0), .o_overrun(ovr0), .o_short(sh0), .o_REC_STATE(st0));

    adc_capture #(.DATA_W(16), .CHANNELS(1), .DEPTH(4)) u_mono (
        .i_BCLK(clk), .i_rst(rst), .i_record(record1), .i_ADCLRCK(lrck), .i_ADCDAT(dat),
        .i_ready(ready1), .i_clr_err(clr), .o_data(d1), .o_channel(ch1), .o_valid(v1),
        .o_count(cnt1), .o_overrun(ovr1), .o_short(sh1), .o_REC_STATE(st1));

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (!rst && v0 && ready) begin
            if (q0.size() == 0) begin
                n_vec++;
                n_bad++;
                $display("FAIL stereo_pop: unexpected word 0x%0h, expected none", {ch0, d0});
            end else begin
                chk("stereo_pop", {15'd0, ch0, d0}, {15'd0, q0.pop_front()});
            end
        end
    end

    always @(negedge clk) begin
        if (!rst && v1 && ready1) begin
            if (q1.size() == 0) begin
                n_vec++;
                n_bad++;
                $display("FAIL mono_pop: unexpected word 0x%0h, expected none", {ch1, d1});
            end else begin
                chk("mono_pop", {15'd0, ch1, d1}, {15'd0, q1.pop_front()});
            end
        end
    end

    // One LRCK half-period: ncyc clocks at level lr, nbits of w MSB first after off pad bits.
    task automatic half(input logic lr, input logic [15:0] w, input int nbits, input int ncyc, input int off);
        for (int c = 0; c < ncyc; c++) begin
            @(posedge clk);
            #1;
            lrck = lr;
            if (c < off)                dat = 1'b0;
            else if (c - off < nbits)   dat = w[15 - (c - off)];
            else                        dat = 1'b1;
        end
    endtask

    task automatic drain();
        for (int i = 0; i < 200 && (q0.size() != 0 || q1.size() != 0); i++) @(posedge clk);
        @(negedge clk);
        chk("drain_left", q0.size() + q1.size(), 0);
    endtask

    task automatic pulse_clr();
        @(posedge clk); #1 clr = 1'b1;
        @(posedge clk); #1 clr = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        rst = 1'b1; record = 1'b1; record1 = 1'b0; lrck = 1'b1; dat = 1'b0;
        ready = 1'b1; clr = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_state", st0, S_IDLE);
        chk("rst_valid", v0, 0);
        chk("rst_count", cnt0, 0);
        chk("rst_data", {ch0, d0}, 0);
        chk("rst_flags", {ovr0, sh0}, 0);

        @(posedge clk); #1 rst = 1'b0;
        @(posedge clk); @(negedge clk);
        chk("arm_sync", st0, S_SYNC);

        // Basic stereo frame
        q0.push_back({CH_LEFT, 16'hA5C3});
        half(1'b0, 16'hA5C3, 16, 20, DLY);
        q0.push_back({CH_RIGHT, 16'h1234});
        half(1'b1, 16'h1234, 16, 20, DLY);
        drain();
        chk("basic_short", sh0, 0);

        // Data delayed one bit after the LRCK edge
        q0.push_back({CH_LEFT, (DLY != 0) ? 16'hB6D9 : 16'h5B6C});
        half(1'b0, 16'hB6D9, 16, 20, 1);
        q0.push_back({CH_RIGHT, 16'h0F0F});
        half(1'b1, 16'h0F0F, 16, 20, DLY);
        drain();
        chk("delay_short", sh0, 0);

        // LRCK flips after 10 bits: partial left dropped, right word still good
        half(1'b0, 16'hFFFF, 10, 10, DLY);
        q0.push_back({CH_RIGHT, 16'hC001});
        half(1'b1, 16'hC001, 16, 20, DLY);
        @(negedge clk);
        chk("short_set", sh0, 1);
        pulse_clr();
        chk("short_clr", sh0, 0);
        q0.push_back({CH_LEFT, 16'h7E81});
        half(1'b0, 16'h7E81, 16, 20, DLY);
        q0.push_back({CH_RIGHT, 16'h0001});
        half(1'b1, 16'h0001, 16, 20, DLY);
        drain();

        // Overrun: consumer stalled, fifth word dropped
        @(posedge clk); #1 ready = 1'b0;
        q0.push_back({CH_LEFT, 16'h1001});  half(1'b0, 16'h1001, 16, 20, DLY);
        q0.push_back({CH_RIGHT, 16'h2002}); half(1'b1, 16'h2002, 16, 20, DLY);
        q0.push_back({CH_LEFT, 16'h3003});  half(1'b0, 16'h3003, 16, 20, DLY);
        q0.push_back({CH_RIGHT, 16'h4004}); half(1'b1, 16'h4004, 16, 20, DLY);
        half(1'b0, 16'h5005, 16, 20, DLY);
        @(negedge clk);
        chk("ovr_count", cnt0, 4);
        chk("ovr_flag", ovr0, 1);
        pulse_clr();
        chk("ovr_clr", ovr0, 0);
        chk("ovr_count_kept", cnt0, 4);
        @(posedge clk); #1 ready = 1'b1;
        drain();

        // Recording dropped mid-word; resync must wait for a falling LRCK edge
        q0.push_back({CH_RIGHT, 16'h0BAD});
        half(1'b1, 16'h0BAD, 16, 20, DLY);
        half(1'b0, 16'hAAAA, 16, 6, DLY);
        @(posedge clk); #1 record = 1'b0;
        @(posedge clk); @(negedge clk);
        chk("drop_idle", st0, S_IDLE);
        @(posedge clk); #1 record = 1'b1;
        @(posedge clk); @(negedge clk);
        chk("rearm_sync", st0, S_SYNC);
        half(1'b1, 16'h3C3C, 16, 20, DLY);
        @(negedge clk);
        chk("rise_ignored", st0, S_SYNC);
        q0.push_back({CH_LEFT, 16'h5A5A});
        half(1'b0, 16'h5A5A, 16, 20, DLY);
        q0.push_back({CH_RIGHT, 16'h6B6B});
        half(1'b1, 16'h6B6B, 16, 20, DLY);
        drain();

        // Mono companion captures left words only
        @(posedge clk); #1 record1 = 1'b1;
        q0.push_back({CH_LEFT, 16'h1111});  q1.push_back({CH_LEFT, 16'h1111});
        half(1'b0, 16'h1111, 16, 20, DLY);
        q0.push_back({CH_RIGHT, 16'h2222});
        half(1'b1, 16'h2222, 16, 20, DLY);
        q0.push_back({CH_LEFT, 16'h3333});  q1.push_back({CH_LEFT, 16'h3333});
        half(1'b0, 16'h3333, 16, 20, DLY);
        q0.push_back({CH_RIGHT, 16'h4444});
        half(1'b1, 16'h4444, 16, 20, DLY);
        drain();
        chk("mono_hold", st1, S_HOLD);
        chk("mono_short", sh1, 0);
        chk("end_count", {cnt1, cnt0}, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

    initial begin
        #300000;
        n_bad++;
        $display("FAIL timeout: simulation still running, expected completion");
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
